reset_sequencer: RTL and testbench

- Master-clock-domain reset controller that generalises per-domain reset generation to a sequenced, N-channel power-up/shutdown manager.
- Holds all domain resets, releases them in index order with an acknowledge handshake per domain, and on request performs a shutdown: assert all resets, confirm, then gate clocks.
- Acks are domain reset states already synchronised into clk (external async_signal_sync per channel).
- Sits next to per-domain reset_sync blocks; its domain_resn_out feeds their resn_in.

---
 rtl/reset_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Master-clock reset sequencer: holds all domain resets, releases them in index order
// with a per-domain acknowledge handshake, and on request shuts every domain down
// (assert resets, confirm, then gate clocks). All outputs are registered.
module reset_sequencer #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CLK_SETTLE  = 8
) (
  input  logic                clk,
  input  logic                resn,
  input  logic                restart_req,
  input  logic                shutdown_req,
  input  logic [CHANNELS-1:0] domain_resn_ack,
  output logic [CHANNELS-1:0] domain_resn_out,
  output logic [CHANNELS-1:0] clk_en_out,
  output logic                all_ready,
  output logic                all_in_reset,
  output logic                busy,
  output logic                timeout_err
);

  // Elaboration-time sanity checks on the configuration.
  if (CHANNELS < 1) begin : g_chk_channels
    $error("reset_sequencer: CHANNELS must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (ACK_TIMEOUT < 1) begin : g_chk_timeout
    $error("reset_sequencer: ACK_TIMEOUT must be >= 1");
  end
  if (CLK_SETTLE < 1) begin : g_chk_settle
    $error("reset_sequencer: CLK_SETTLE must be >= 1");
  end

  // One shared counter, sized for the longest interval it ever has to hold.
  localparam int unsigned Max01  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned Max23  = (ACK_TIMEOUT > CLK_SETTLE) ? ACK_TIMEOUT : CLK_SETTLE;
  localparam int unsigned MaxCnt = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Terminal counts. HOLD and GAP release on the edge after the count completes (so a
  // zero gap releases on the very next edge); the others act on the edge that completes it.
  localparam logic [CntW-1:0] HoldEnd     = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] GapEnd      = CntW'(STAGE_GAP);
  localparam logic [CntW-1:0] AckEnd      = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0] ShutHoldEnd = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] SettleEnd   = CntW'(CLK_SETTLE - 1);
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(CHANNELS - 1);

  typedef enum logic [3:0] {
    StHold,        // all resets asserted, counting the hold interval
    StWaitAck,     // current channel released, waiting for its ack
    StGap,         // idle gap before releasing the next channel
    StRun,         // every domain out of reset
    StShutAssert,  // resets just asserted for shutdown
    StShutWait,    // waiting for all acks to drop
    StShutHold,    // acks low, holding before gating clocks
    StOff,         // clocks gated, resets held
    StClkOn        // clocks re-enabled, letting them settle
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CHANNELS-1:0] resn_q, resn_d;
  logic [CHANNELS-1:0] clk_en_q, clk_en_d;
  logic                terr_q, terr_d;
  logic                ready_q, busy_q, air_q;

  logic [IdxW-1:0]     idx_inc;
  logic [CHANNELS-1:0] idx_bit, next_bit;
  logic                ack_hit, acks_low;
  logic                in_sequence, shut_ok;

  // Channel decode and request qualification.
  always_comb begin
    idx_inc     = idx_q + 1'b1;
    idx_bit     = CHANNELS'(1) << idx_q;
    next_bit    = CHANNELS'(1) << idx_inc;
    // Only the channel currently being released can complete the handshake.
    ack_hit     = |(domain_resn_ack & idx_bit);
    acks_low    = ~|domain_resn_ack;
    in_sequence = state_q inside {StHold, StWaitAck, StGap, StRun};
    shut_ok     = in_sequence || (state_q == StClkOn);
  end

  // Next-state and next-output logic; requests take priority over normal sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    resn_d   = resn_q;
    clk_en_d = clk_en_q;
    terr_d   = terr_q;

    if (shutdown_req && shut_ok) begin
      // Shutdown beats a simultaneous restart and aborts any sequence in progress.
      state_d = StShutAssert;
      resn_d  = '0;
      cnt_d   = '0;
    end else if (restart_req && in_sequence) begin
      state_d = StHold;
      resn_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
      terr_d  = 1'b0;
    end else if (restart_req && (state_q == StOff)) begin
      state_d  = StClkOn;
      clk_en_d = '1;
      cnt_d    = '0;
      terr_d   = 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          if (cnt_q == HoldEnd) begin
            resn_d  = resn_q | idx_bit;
            cnt_d   = '0;
            state_d = StWaitAck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitAck: begin
          if (ack_hit || (cnt_q == AckEnd)) begin
            // A timeout is flagged but otherwise treated exactly like an ack.
            if (!ack_hit) begin
              terr_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = (idx_q == LastIdx) ? StRun : StGap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapEnd) begin
            idx_d   = idx_inc;
            resn_d  = resn_q | next_bit;
            cnt_d   = '0;
            state_d = StWaitAck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          // Acks dropping here are deliberately not acted on.
        end
        StShutAssert: begin
          cnt_d   = '0;
          state_d = StShutWait;
        end
        StShutWait: begin
          if (acks_low || (cnt_q == AckEnd)) begin
            if (!acks_low) begin
              terr_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = StShutHold;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShutHold: begin
          if (cnt_q == ShutHoldEnd) begin
            clk_en_d = '0;
            cnt_d    = '0;
            state_d  = StOff;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOff: begin
          // Wait for a restart request.
        end
        StClkOn: begin
          if (cnt_q == SettleEnd) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StHold;
          resn_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resn) begin
      state_q  <= StHold;
      cnt_q    <= '0;
      idx_q    <= '0;
      resn_q   <= '0;
      clk_en_q <= '1;
      terr_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      air_q    <= acks_low;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      resn_q   <= resn_d;
      clk_en_q <= clk_en_d;
      terr_q   <= terr_d;
      ready_q  <= (state_d == StRun);
      busy_q   <= !(state_d inside {StRun, StOff});
      air_q    <= (resn_d == '0) && acks_low;
    end
  end

  assign domain_resn_out = resn_q;
  assign clk_en_out      = clk_en_q;
  assign all_ready       = ready_q;
  assign all_in_reset    = air_q;
  assign busy            = busy_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default 3-channel build and a 1-channel / zero-gap build,
// compared every cycle against a timestamp-based reference model, plus directed timing checks.
module tb_reset_sequencer;

  localparam int HOLD   = 16;
  localparam int GAP    = 4;
  localparam int TO     = 64;
  localparam int SETTLE = 8;

  logic master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  // Stimulus. ackv[2:0] feeds build A, ackv[3] feeds build B.
  logic       a_resn = 1'b0, a_rr = 1'b0, a_sr = 1'b0;
  logic       b_resn = 1'b0, b_rr = 1'b0, b_sr = 1'b0;
  logic [3:0] ackv   = '0;
  logic [3:0] stuck  = '0;

  logic [2:0] a_rout, a_cen;
  logic       a_ready, a_air, a_busy, a_terr;
  logic [0:0] b_rout, b_cen;
  logic       b_ready, b_air, b_busy, b_terr;

  reset_sequencer #(
    .CHANNELS(3), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .ACK_TIMEOUT(TO), .CLK_SETTLE(SETTLE)
  ) u_dut_a (
    .clk             (master_clk),
    .resn            (a_resn),
    .restart_req     (a_rr),
    .shutdown_req    (a_sr),
    .domain_resn_ack (ackv[2:0]),
    .domain_resn_out (a_rout),
    .clk_en_out      (a_cen),
    .all_ready       (a_ready),
    .all_in_reset    (a_air),
    .busy            (a_busy),
    .timeout_err     (a_terr)
  );

  reset_sequencer #(
    .CHANNELS(1), .HOLD_CYCLES(HOLD), .STAGE_GAP(0), .ACK_TIMEOUT(TO), .CLK_SETTLE(SETTLE)
  ) u_dut_b (
    .clk             (master_clk),
    .resn            (b_resn),
    .restart_req     (b_rr),
    .shutdown_req    (b_sr),
    .domain_resn_ack (ackv[3:3]),
    .domain_resn_out (b_rout),
    .clk_en_out      (b_cen),
    .all_ready       (b_ready),
    .all_in_reset    (b_air),
    .busy            (b_busy),
    .timeout_err     (b_terr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases with absolute deadlines (edge numbers) instead of counters.
  typedef enum int {PHold, PWait, PGap, PRun, PShA, PShW, PShH, POff, PClk} ph_e;
  typedef struct {
    ph_e ph;
    int  due;
    int  idx;
    int  mask;
    int  clken;
    bit  terr;
    bit  air;
  } mdl_t;

  mdl_t ma, mb;
  int   cyc = 0;

  function automatic mdl_t mstep(input mdl_t m, input int t, input int nch, input int gap,
                                 input bit rsn, input bit rr, input bit sr, input int ack);
    mdl_t n;
    int   all;
    bit   got;
    n   = m;
    all = (1 << nch) - 1;
    got = ((ack >> m.idx) & 1) == 1;
    if (!rsn) begin
      n.ph = PHold; n.due = t + HOLD + 1; n.idx = 0; n.mask = 0; n.clken = all; n.terr = 1'b0;
    end else if (sr && (m.ph inside {PHold, PWait, PGap, PRun, PClk})) begin
      n.ph = PShA; n.mask = 0;
    end else if (rr && (m.ph inside {PHold, PWait, PGap, PRun})) begin
      n.ph = PHold; n.due = t + HOLD + 1; n.idx = 0; n.mask = 0; n.terr = 1'b0;
    end else if (rr && m.ph == POff) begin
      n.ph = PClk; n.due = t + SETTLE; n.clken = all; n.terr = 1'b0;
    end else begin
      case (m.ph)
        PHold: if (t == m.due) begin
          n.mask = m.mask | (1 << m.idx); n.ph = PWait; n.due = t + TO;
        end
        PWait: if (got || t == m.due) begin
          if (!got) n.terr = 1'b1;
          if (m.idx == nch - 1) n.ph = PRun;
          else begin n.ph = PGap; n.due = t + gap + 1; end
        end
        PGap: if (t == m.due) begin
          n.idx = m.idx + 1; n.mask = m.mask | (1 << (m.idx + 1)); n.ph = PWait; n.due = t + TO;
        end
        PShA: begin n.ph = PShW; n.due = t + TO; end
        PShW: if (ack == 0 || t == m.due) begin
          if (ack != 0) n.terr = 1'b1;
          n.ph = PShH; n.due = t + HOLD;
        end
        PShH: if (t == m.due) begin n.ph = POff; n.clken = 0; end
        PClk: if (t == m.due) begin n.ph = PHold; n.due = t + HOLD + 1; n.idx = 0; end
        default: ;
      endcase
    end
    n.air = (n.mask == 0) && (ack == 0);
    return n;
  endfunction

  // Ack responder: each ack follows its expected reset release after a delay.
  bit rand_mode = 1'b0;
  int fix_dly   = 3;
  int acnt[4];
  int adly[4];

  function automatic int next_dly();
    if (!rand_mode) return fix_dly;
    if ($urandom_range(0, 7) == 0) return 70;  // long enough to force a timeout
    return int'($urandom_range(1, 8));
  endfunction

  task automatic set_dly(input int d);
    fix_dly = d;
    for (int i = 0; i < 4; i++) begin
      adly[i] = d;
      acnt[i] = 0;
    end
  endtask

  task automatic resp_step();
    logic [3:0] tgt;
    logic       want;
    tgt = {mb.mask[0], ma.mask[2:0]};
    for (int i = 0; i < 4; i++) begin
      want = tgt[i] && !stuck[i];
      if (ackv[i] != want) begin
        acnt[i]++;
        if (acnt[i] >= adly[i]) begin
          ackv[i] = want;
          acnt[i] = 0;
          adly[i] = next_dly();
        end
      end else begin
        acnt[i] = 0;
      end
      if (rand_mode && $urandom_range(0, 149) == 0) ackv[i] = ~ackv[i];
    end
  endtask

  task automatic tick();
    @(posedge master_clk);
    cyc++;
    ma = mstep(ma, cyc, 3, GAP, a_resn, a_rr, a_sr, int'(ackv[2:0]));
    mb = mstep(mb, cyc, 1, 0, b_resn, b_rr, b_sr, int'(ackv[3]));
    @(negedge master_clk);
    check_eq("a_resn_out",     32'(a_rout),  32'(ma.mask));
    check_eq("a_clk_en",       32'(a_cen),   32'(ma.clken));
    check_eq("a_all_ready",    32'(a_ready), 32'(ma.ph == PRun));
    check_eq("a_busy",         32'(a_busy),  32'(!(ma.ph inside {PRun, POff})));
    check_eq("a_all_in_reset", 32'(a_air),   32'(ma.air));
    check_eq("a_timeout_err",  32'(a_terr),  32'(ma.terr));
    check_eq("b_resn_out",     32'(b_rout),  32'(mb.mask));
    check_eq("b_clk_en",       32'(b_cen),   32'(mb.clken));
    check_eq("b_all_ready",    32'(b_ready), 32'(mb.ph == PRun));
    check_eq("b_busy",         32'(b_busy),  32'(!(mb.ph inside {PRun, POff})));
    check_eq("b_all_in_reset", 32'(b_air),   32'(mb.air));
    check_eq("b_timeout_err",  32'(b_terr),  32'(mb.terr));
    resp_step();
  endtask

  initial begin
    int n;
    set_dly(3);

    // Reset values.
    repeat (3) tick();
    check_eq("rst_clk_en", 32'(a_cen), 32'd7);
    check_eq("rst_busy", 32'(a_busy), 32'd1);

    // Power-up: release timing with acks 3 cycles after each release.
    a_resn = 1'b1;
    n = 0; do begin tick(); n++; end while (!a_rout[0] && n < 200);
    check_eq("t_rel0", 32'(n), 32'(HOLD + 1));
    n = 0; do begin tick(); n++; end while (!a_rout[1] && n < 200);
    check_eq("t_rel1", 32'(n), 32'(3 + GAP + 1));
    n = 0; do begin tick(); n++; end while (!a_rout[2] && n < 200);
    check_eq("t_rel2", 32'(n), 32'(3 + GAP + 1));
    n = 0; do begin tick(); n++; end while (!a_ready && n < 200);
    check_eq("t_ready", 32'(n), 32'd3);
    check_eq("pu_terr", 32'(a_terr), 32'd0);

    // Restart from RUN with ack[1] stuck low: timeout, then channel 2 still released.
    stuck[1] = 1'b1;
    a_rr = 1'b1; tick(); a_rr = 1'b0;
    check_eq("rr_resn_out", 32'(a_rout), 32'd0);
    n = 0; do begin tick(); n++; end while (!a_rout[1] && n < 200);
    n = 0; do begin tick(); n++; end while (!a_terr && n < 200);
    check_eq("t_timeout", 32'(n), 32'(TO));
    n = 0; do begin tick(); n++; end while (!a_rout[2] && n < 200);
    check_eq("t_rel2_after_to", 32'(n), 32'(GAP + 1));
    n = 0; do begin tick(); n++; end while (!a_ready && n < 200);
    check_eq("to_ready", 32'(a_ready), 32'd1);
    stuck[1] = 1'b0;
    repeat (6) tick();

    // Shutdown from RUN, acks fall 2 cycles later.
    set_dly(2);
    a_sr = 1'b1; tick(); a_sr = 1'b0;
    check_eq("sd_resn_out", 32'(a_rout), 32'd0);
    n = 0; do begin tick(); n++; end while (ackv[2:0] != 3'b000 && n < 20);
    // One edge samples the acks low, then HOLD cycles until the clocks are gated.
    n = 0; do begin tick(); n++; end while (a_cen != 3'b000 && n < 200);
    check_eq("t_gate", 32'(n), 32'(HOLD + 1));
    check_eq("off_all_in_reset", 32'(a_air), 32'd1);
    check_eq("off_busy", 32'(a_busy), 32'd0);
    repeat (3) tick();

    // Restart from OFF: clocks back at once, settle, then a full release sequence.
    set_dly(3);
    a_rr = 1'b1; tick(); a_rr = 1'b0;
    check_eq("on_clk_en", 32'(a_cen), 32'd7);
    check_eq("on_terr_clr", 32'(a_terr), 32'd0);
    n = 0; do begin tick(); n++; end while (!a_rout[0] && n < 200);
    check_eq("t_on_rel0", 32'(n), 32'(SETTLE + HOLD + 1));
    n = 0; do begin tick(); n++; end while (!a_ready && n < 200);
    check_eq("t_on_ready", 32'(n), 32'(3 * 3 + 2 * (GAP + 1)));

    // Restart and shutdown together during WAIT_ACK: shutdown wins.
    a_rr = 1'b1; tick(); a_rr = 1'b0;
    n = 0; do begin tick(); n++; end while (!a_rout[0] && n < 200);
    tick();
    a_rr = 1'b1; a_sr = 1'b1; tick(); a_rr = 1'b0; a_sr = 1'b0;
    check_eq("both_resn_out", 32'(a_rout), 32'd0);
    n = 0; do begin tick(); n++; end while (a_cen != 3'b000 && n < 200);
    check_eq("both_off", 32'(a_cen), 32'd0);

    // One-channel build: reset in the middle of WAIT_ACK, then a clean restart.
    stuck[3] = 1'b1;
    b_resn = 1'b1;
    n = 0; do begin tick(); n++; end while (!b_rout[0] && n < 200);
    check_eq("b_t_rel0", 32'(n), 32'(HOLD + 1));
    repeat (10) tick();
    b_resn = 1'b0; tick();
    check_eq("b_mid_rst_resn", 32'(b_rout), 32'd0);
    check_eq("b_mid_rst_busy", 32'(b_busy), 32'd1);
    b_resn = 1'b1; stuck[3] = 1'b0;
    n = 0; do begin tick(); n++; end while (!b_rout[0] && n < 200);
    check_eq("b_t_rel0_again", 32'(n), 32'(HOLD + 1));
    n = 0; do begin tick(); n++; end while (!b_ready && n < 200);
    check_eq("b_t_ready", 32'(n), 32'd3);

    // Randomized traffic on both builds.
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      a_resn = ($urandom_range(0, 299) != 0);
      b_resn = ($urandom_range(0, 299) != 0);
      a_rr   = ($urandom_range(0, 79) == 0);
      a_sr   = ($urandom_range(0, 79) == 0);
      b_rr   = ($urandom_range(0, 79) == 0);
      b_sr   = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
